// File: rtl/csr_pkg.sv
// Shared definitions for the CSR file: addresses, field layouts, exception codes
// and the set of exception codes that capture a faulting address.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00c;
  localparam logic [13:0] CSR_SAVE0     = 14'h030;
  localparam logic [13:0] CSR_SAVE1     = 14'h031;
  localparam logic [13:0] CSR_SAVE2     = 14'h032;
  localparam logic [13:0] CSR_SAVE3     = 14'h033;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  typedef struct packed {
    logic [1:0] datm;
    logic [1:0] datf;
    logic       pg;
    logic       da;
    logic       ie;
    logic [1:0] plv;
  } crmd_t;

  localparam crmd_t CRMD_RESET = '{datm: 2'b00, datf: 2'b00, pg: 1'b0, da: 1'b1,
                                   ie: 1'b0, plv: 2'b00};

  // LIE bit 10 has no interrupt source behind it
  localparam logic [12:0] ECFG_LIE_WMASK = 13'h1bff;

  typedef enum logic [5:0] {
    ECODE_INT  = 6'h00,
    ECODE_PIL  = 6'h01,
    ECODE_PIS  = 6'h02,
    ECODE_PIF  = 6'h03,
    ECODE_PME  = 6'h04,
    ECODE_PPI  = 6'h07,
    ECODE_ADE  = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0b,
    ECODE_BRK  = 6'h0c,
    ECODE_INE  = 6'h0d,
    ECODE_TLBR = 6'h3f
  } ecode_e;

  function automatic logic ecode_sets_badv(input logic [5:0] ecode);
    return ecode inside {ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME,
                         ECODE_PPI, ECODE_ADE, ECODE_ALE, ECODE_TLBR};
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Interval timer (TCFG/TVAL) with expiry pulse, plus the free-running 64-bit
// stable counter.
module csr_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  output logic        timer_set,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic [63:0] stable_cnt
);

  logic        en;
  logic        periodic;
  logic [31:0] reload_val;

  assign en         = tcfg[0];
  assign periodic   = tcfg[1];
  assign reload_val = {tcfg[31:2], 2'b00};

  // A TCFG write reloads the counter, so it suppresses the expiry pulse
  assign timer_set = !tcfg_we && en && (tval == 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg       <= 32'h0;
      tval       <= 32'h0;
      stable_cnt <= 64'h0;
    end else begin
      stable_cnt <= stable_cnt + 64'd1;
      if (tcfg_we) begin
        tcfg <= tcfg_wdata;
        tval <= {tcfg_wdata[31:2], 2'b00};
      end else if (en) begin
        if (tval != 32'h0)
          tval <= tval - 32'd1;
        else if (periodic)
          tval <= reload_val;
      end
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// LoongArch CSR file: masked CSR writes, exception/ertn commit updates, interrupt
// pending flag and redirect targets. Timer state lives in csr_timer.
module csr_regfile #(
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_tlbr,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic [63:0] stable_cnt
);

  import csr_pkg::*;

  crmd_t       crmd;
  logic [2:0]  prmd;          // {PIE, PPLV}
  logic [12:0] ecfg_lie;
  logic [1:0]  estat_is_sw;
  logic [7:0]  estat_is_hw;
  logic        estat_ti;
  logic        estat_ipi;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [25:0] tlbrentry;
  logic [31:0] save [4];
  logic [31:0] tid;

  logic [31:0] estat_val;
  logic [31:0] csr_cur;
  logic [31:0] wr_data;
  logic        wr_ok;
  logic        tcfg_we;
  logic        ticlr_clr;
  logic        timer_set;
  logic [31:0] tcfg;
  logic [31:0] tval;

  assign estat_val = {1'b0, estat_esub, estat_ecode, 3'b000, estat_ipi, estat_ti,
                      1'b0, estat_is_hw, estat_is_sw};

  always_comb begin
    csr_cur = 32'h0;
    case (csr_num)
      CSR_CRMD:      csr_cur = {23'h0, crmd};
      CSR_PRMD:      csr_cur = {29'h0, prmd};
      CSR_ECFG:      csr_cur = {19'h0, ecfg_lie};
      CSR_ESTAT:     csr_cur = estat_val;
      CSR_ERA:       csr_cur = era;
      CSR_BADV:      csr_cur = badv;
      CSR_EENTRY:    csr_cur = {eentry, 6'h0};
      CSR_SAVE0:     csr_cur = save[0];
      CSR_SAVE1:     csr_cur = save[1];
      CSR_SAVE2:     csr_cur = save[2];
      CSR_SAVE3:     csr_cur = save[3];
      CSR_TID:       csr_cur = tid;
      CSR_TCFG:      csr_cur = tcfg;
      CSR_TVAL:      csr_cur = tval;
      CSR_TLBRENTRY: csr_cur = {tlbrentry, 6'h0};
      default:       csr_cur = 32'h0;
    endcase
  end

  // Read port is idle (zero) when WB has no valid CSR read
  assign csr_rvalue = csr_re ? csr_cur : 32'h0;

  // TICLR reads as 0, so wr_data[0] is exactly wmask&wvalue bit 0 there
  assign wr_data   = (csr_cur & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign wr_ok     = csr_we && !wb_ex && !ertn_flush;
  assign tcfg_we   = wr_ok && (csr_num == CSR_TCFG);
  assign ticlr_clr = wr_ok && (csr_num == CSR_TICLR) && wr_data[0];

  assign has_int    = crmd.ie && |(estat_val[12:0] & ecfg_lie);
  assign ex_entry   = wb_tlbr ? {tlbrentry, 6'h0} : {eentry, 6'h0};
  assign ertn_entry = era;

  csr_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (tcfg_we),
    .tcfg_wdata (wr_data),
    .timer_set  (timer_set),
    .tcfg       (tcfg),
    .tval       (tval),
    .stable_cnt (stable_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd        <= CRMD_RESET;
      prmd        <= 3'h0;
      ecfg_lie    <= 13'h0;
      estat_is_sw <= 2'h0;
      estat_ecode <= 6'h0;
      estat_esub  <= 9'h0;
      era         <= 32'h0;
      badv        <= 32'h0;
      eentry      <= 26'h0;
      tlbrentry   <= 26'h0;
      for (int i = 0; i < 4; i++) save[i] <= 32'h0;
      tid         <= CORE_ID;
    end else if (wb_ex) begin
      prmd        <= {crmd.ie, crmd.plv};
      crmd.plv    <= 2'b00;
      crmd.ie     <= 1'b0;
      if (wb_tlbr) begin
        crmd.da <= 1'b1;
        crmd.pg <= 1'b0;
      end
      estat_ecode <= wb_ecode;
      estat_esub  <= wb_esubcode;
      era         <= wb_pc;
      if (ecode_sets_badv(wb_ecode))
        badv <= wb_vaddr;
    end else if (ertn_flush) begin
      crmd.plv <= prmd[1:0];
      crmd.ie  <= prmd[2];
      // Returning from a TLB refill handler re-enables mapped translation
      if (estat_ecode == ECODE_TLBR) begin
        crmd.da <= 1'b0;
        crmd.pg <= 1'b1;
      end
    end else if (csr_we) begin
      case (csr_num)
        CSR_CRMD:      crmd        <= crmd_t'(wr_data[8:0]);
        CSR_PRMD:      prmd        <= wr_data[2:0];
        CSR_ECFG:      ecfg_lie    <= wr_data[12:0] & ECFG_LIE_WMASK;
        CSR_ESTAT:     estat_is_sw <= wr_data[1:0];
        CSR_ERA:       era         <= wr_data;
        CSR_BADV:      badv        <= wr_data;
        CSR_EENTRY:    eentry      <= wr_data[31:6];
        CSR_SAVE0:     save[0]     <= wr_data;
        CSR_SAVE1:     save[1]     <= wr_data;
        CSR_SAVE2:     save[2]     <= wr_data;
        CSR_SAVE3:     save[3]     <= wr_data;
        CSR_TID:       tid         <= wr_data;
        CSR_TLBRENTRY: tlbrentry   <= wr_data[31:6];
        default: ;
      endcase
    end
  end

  // Interrupt lines are sampled every cycle regardless of commit activity
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      estat_is_hw <= 8'h0;
      estat_ipi   <= 1'b0;
      estat_ti    <= 1'b0;
    end else begin
      estat_is_hw <= hw_int_in;
      estat_ipi   <= ipi_int_in;
      if (timer_set)
        estat_ti <= 1'b1;
      else if (ticlr_clr)
        estat_ti <= 1'b0;
    end
  end

endmodule
